// File: rtl/level_monitor.sv
// Level monitor for the filtered power word: windowed peak through a one-entry
// valid/ready buffer, plus a debounced above/below decision with hysteresis.
module level_monitor #(
    parameter int WIDTH = 28,
    parameter int DEB_W = 8,
    parameter int DEC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] signal_in,
    input  logic [WIDTH-1:0] thresh_hi,
    input  logic [WIDTH-1:0] thresh_lo,
    input  logic [DEB_W-1:0] debounce,
    input  logic [DEC_W-1:0] decim,
    output logic [WIDTH-1:0] level_data,
    output logic             level_valid,
    input  logic             level_ready,
    output logic             above,
    output logic             event_pulse,
    output logic             overrun
);

    localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};
    localparam logic [DEC_W-1:0] DEC_ZERO = {DEC_W{1'b0}};
    localparam logic [DEC_W-1:0] DEC_ONE  = {{(DEC_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DAT_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [DEB_W-1:0] deb_cnt_next_s;
    logic [DEC_W-1:0] win_cnt_r;
    logic [WIDTH-1:0] peak_r;
    logic [WIDTH-1:0] peak_next_s;
    logic             qual_up_s;
    logic             qual_dn_s;
    logic             win_end_s;
    logic             transfer_s;
    logic             load_s;
    logic             edge_event_s;

    assign qual_up_s  = (signal_in > thresh_hi);
    assign qual_dn_s  = (signal_in < thresh_lo);
    assign win_end_s  = enable && (win_cnt_r == decim);
    assign transfer_s = level_valid && level_ready;
    // A finished window may only enter the buffer if it is empty or draining now.
    assign load_s     = win_end_s && (!level_valid || transfer_s);

    // Running peak including the current sample; first sample of a window restarts it.
    always_comb begin
        peak_next_s = peak_r;
        if (win_cnt_r == DEC_ZERO) begin
            peak_next_s = signal_in;
        end else if (signal_in > peak_r) begin
            peak_next_s = signal_in;
        end else begin
            peak_next_s = peak_r;
        end
    end

    // Detector next-state: debounce counter counts consecutive qualifying samples.
    always_comb begin
        state_next_s   = state_r;
        deb_cnt_next_s = deb_cnt_r;
        edge_event_s   = 1'b0;
        case (state_r)
            ST_LOW: begin
                if (qual_up_s && (debounce == DEB_ZERO)) begin
                    state_next_s   = ST_HIGH;
                    deb_cnt_next_s = DEB_ZERO;
                    edge_event_s   = 1'b1;
                end else if (qual_up_s) begin
                    state_next_s   = ST_RISE;
                    deb_cnt_next_s = DEB_ONE;
                end else begin
                    state_next_s   = ST_LOW;
                end
            end
            ST_RISE: begin
                if (qual_up_s && (deb_cnt_r == debounce)) begin
                    state_next_s   = ST_HIGH;
                    deb_cnt_next_s = DEB_ZERO;
                    edge_event_s   = 1'b1;
                end else if (qual_up_s) begin
                    deb_cnt_next_s = deb_cnt_r + DEB_ONE;
                end else begin
                    state_next_s   = ST_LOW;
                    deb_cnt_next_s = DEB_ZERO;
                end
            end
            ST_HIGH: begin
                if (qual_dn_s && (debounce == DEB_ZERO)) begin
                    state_next_s   = ST_LOW;
                    deb_cnt_next_s = DEB_ZERO;
                    edge_event_s   = 1'b1;
                end else if (qual_dn_s) begin
                    state_next_s   = ST_FALL;
                    deb_cnt_next_s = DEB_ONE;
                end else begin
                    state_next_s   = ST_HIGH;
                end
            end
            ST_FALL: begin
                if (qual_dn_s && (deb_cnt_r == debounce)) begin
                    state_next_s   = ST_LOW;
                    deb_cnt_next_s = DEB_ZERO;
                    edge_event_s   = 1'b1;
                end else if (qual_dn_s) begin
                    deb_cnt_next_s = deb_cnt_r + DEB_ONE;
                end else begin
                    state_next_s   = ST_HIGH;
                    deb_cnt_next_s = DEB_ZERO;
                end
            end
            default: begin
                state_next_s   = ST_LOW;
                deb_cnt_next_s = DEB_ZERO;
            end
        endcase
    end

    // Detector state, debounce counter and registered decision outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_LOW;
            deb_cnt_r   <= DEB_ZERO;
            above       <= 1'b0;
            event_pulse <= 1'b0;
        end else if (enable) begin
            state_r     <= state_next_s;
            deb_cnt_r   <= deb_cnt_next_s;
            above       <= (state_next_s == ST_HIGH) || (state_next_s == ST_FALL);
            event_pulse <= edge_event_s;
        end else begin
            event_pulse <= 1'b0;
        end
    end

    // Window counter wraps on reaching decim or by natural overflow if decim was lowered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_r <= DEC_ZERO;
            peak_r    <= DAT_ZERO;
        end else if (enable) begin
            peak_r    <= peak_next_s;
            win_cnt_r <= win_end_s ? DEC_ZERO : (win_cnt_r + DEC_ONE);
        end else begin
            peak_r    <= peak_r;
            win_cnt_r <= win_cnt_r;
        end
    end

    // Single-entry result buffer; a result arriving while full is dropped and flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_data  <= DAT_ZERO;
            level_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (load_s) begin
            level_data  <= peak_next_s;
            level_valid <= 1'b1;
        end else if (win_end_s) begin
            overrun     <= 1'b1;
        end else if (transfer_s) begin
            level_valid <= 1'b0;
        end else begin
            level_valid <= level_valid;
        end
    end

endmodule

// File: tb/tb_level_monitor.sv
// Self-checking bench for level_monitor: directed scenarios plus randomized
// traffic compared every cycle against a sample-list / run-length reference model.
module tb_level_monitor;

    localparam int WIDTH = 28;
    localparam int DEB_W = 8;
    localparam int DEC_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] signal_in;
    logic [WIDTH-1:0] thresh_hi;
    logic [WIDTH-1:0] thresh_lo;
    logic [DEB_W-1:0] debounce;
    logic [DEC_W-1:0] decim;
    logic [WIDTH-1:0] level_data;
    logic             level_valid;
    logic             level_ready;
    logic             above;
    logic             event_pulse;
    logic             overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit               m_above;
    bit               m_event;
    bit               m_valid;
    bit               m_overrun;
    logic [WIDTH-1:0] m_data;
    int               m_run;
    logic [WIDTH-1:0] m_win[$];

    level_monitor #(.WIDTH(WIDTH), .DEB_W(DEB_W), .DEC_W(DEC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .signal_in   (signal_in),
        .thresh_hi   (thresh_hi),
        .thresh_lo   (thresh_lo),
        .debounce    (debounce),
        .decim       (decim),
        .level_data  (level_data),
        .level_valid (level_valid),
        .level_ready (level_ready),
        .above       (above),
        .event_pulse (event_pulse),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_above   = 1'b0;
        m_event   = 1'b0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_data    = '0;
        m_run     = 0;
        m_win.delete();
    endtask

    // One clock edge of the reference: window = list of samples, decision = run length.
    task automatic model_step();
        bit               xfer;
        bit               have_res;
        bit               qual;
        logic [WIDTH-1:0] res;
        xfer     = m_valid && level_ready;
        have_res = 1'b0;
        res      = '0;
        m_event  = 1'b0;
        if (enable) begin
            m_win.push_back(signal_in);
            if (m_win.size() == int'(decim) + 1) begin
                have_res = 1'b1;
                foreach (m_win[i]) if (m_win[i] > res) res = m_win[i];
                m_win.delete();
            end
            qual = m_above ? (signal_in < thresh_lo) : (signal_in > thresh_hi);
            m_run = qual ? m_run + 1 : 0;
            if (m_run == int'(debounce) + 1) begin
                m_above = !m_above;
                m_event = 1'b1;
                m_run   = 0;
            end
        end
        if (have_res && (!m_valid || xfer)) begin
            m_data  = res;
            m_valid = 1'b1;
        end else if (have_res) begin
            m_overrun = 1'b1;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_value("level_data", 32'(level_data), 32'(m_data));
        check_value("level_valid", 32'(level_valid), 32'(m_valid));
        check_value("above", 32'(above), 32'(m_above));
        check_value("event", 32'(event_pulse), 32'(m_event));
        check_value("overrun", 32'(overrun), 32'(m_overrun));
    endtask

    task automatic step(input bit en, input logic [WIDTH-1:0] s, input bit rdy);
        enable      = en;
        signal_in   = s;
        level_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] seq[];
        reset = 1'b0; enable = 1'b0; signal_in = '0; level_ready = 1'b0;
        thresh_hi = 28'd1000; thresh_lo = 28'd500; debounce = 8'd2; decim = 16'd3;
        model_reset();
        #1;
        compare_all();

        // Window peak
        do_reset();
        decim = 16'd3;
        seq = '{28'd5, 28'd9, 28'd2, 28'd7, 28'd1, 28'd1, 28'd1, 28'd1};
        foreach (seq[i]) begin
            step(1'b1, seq[i], 1'b1);
            if (i == 3) begin
                check_value("peak1_valid", 32'(level_valid), 32'd1);
                check_value("peak1_data", 32'(level_data), 32'd9);
            end
        end
        check_value("peak2_data", 32'(level_data), 32'd1);
        check_value("peak2_valid", 32'(level_valid), 32'd1);

        // Backpressure and same-edge transfer + reload
        do_reset();
        decim = 16'd0;
        step(1'b1, 28'd10, 1'b0);
        step(1'b1, 28'd20, 1'b0);
        check_value("bp_data", 32'(level_data), 32'd10);
        check_value("bp_overrun", 32'(overrun), 32'd1);
        step(1'b0, 28'd0, 1'b1);
        check_value("bp_drain", 32'(level_valid), 32'd0);
        do_reset();
        step(1'b1, 28'd30, 1'b0);
        step(1'b1, 28'd40, 1'b1);
        check_value("reload_data", 32'(level_data), 32'd40);
        check_value("reload_valid", 32'(level_valid), 32'd1);

        // Hysteresis / debounce
        do_reset();
        debounce = 8'd2; decim = 16'd0;
        seq = '{28'd1200, 28'd1200, 28'd900, 28'd1200, 28'd1200, 28'd1200};
        foreach (seq[i]) begin
            step(1'b1, seq[i], 1'b1);
            if (i == 4) check_value("hyst_hold", 32'(above), 32'd0);
        end
        check_value("hyst_rise", 32'(above), 32'd1);
        check_value("hyst_event", 32'(event_pulse), 32'd1);
        repeat (3) step(1'b1, 28'd400, 1'b1);
        check_value("hyst_fall", 32'(above), 32'd0);

        // Boundary compares
        do_reset();
        debounce = 8'd0;
        step(1'b1, 28'd1000, 1'b1);
        check_value("bnd_1000", 32'(above), 32'd0);
        step(1'b1, 28'd1001, 1'b1);
        check_value("bnd_1001", 32'(above), 32'd1);
        step(1'b1, 28'd500, 1'b1);
        check_value("bnd_500", 32'(above), 32'd1);
        step(1'b1, 28'd499, 1'b1);
        check_value("bnd_499", 32'(above), 32'd0);

        // Enable gating mid-window and mid-RISE, buffer still drains
        do_reset();
        debounce = 8'd5; decim = 16'd2;
        repeat (4) step(1'b1, 28'd1100, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 28'($urandom_range(0, 3000)), i == 5);
        check_value("gate_drain", 32'(level_valid), 32'd0);
        repeat (3) step(1'b1, 28'd1100, 1'b0);
        check_value("gate_above", 32'(above), 32'd1);

        // Async reset between edges
        do_reset();
        debounce = 8'd0; decim = 16'd0;
        step(1'b1, 28'd1200, 1'b0);
        check_value("pre_rst_above", 32'(above), 32'd1);
        reset = 1'b0;
        #2;
        model_reset();
        compare_all();
        #1;
        reset = 1'b1;
        decim = 16'd3;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 28'(i + 1), 1'b1);
            check_value("post_rst_valid", 32'(level_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        check_value("post_rst_data", 32'(level_data), 32'd4);

        // Randomized traffic, one configuration per segment
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            decim     = 16'($urandom_range(0, 4));
            debounce  = 8'($urandom_range(0, 3));
            thresh_hi = 28'($urandom_range(600, 1200));
            thresh_lo = (seg == 5) ? thresh_hi + 28'd100 : 28'($urandom_range(200, 700));
            for (int n = 0; n < 150; n++)
                step($urandom_range(0, 9) < 8, 28'($urandom_range(0, 1600)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
